// File: rtl/ipv4_rx_parser.sv
// IPv4 receive parser: checks the header, strips it and forwards the
// TCP segment bytes through a single output register.
module ipv4_rx_parser #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic [31:0]      src_ip_o,
    output logic [31:0]      dst_ip_o,
    output logic [15:0]      seg_len_o,
    output logic             hdr_valid_o,
    output logic [CNT_W-1:0] ok_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        HDR,
        OPT,
        PAYLOAD,
        DISCARD
    } state_t;

    state_t      state;
    logic [15:0] idx;
    logic [15:0] csum;
    logic [15:0] total_len;
    logic [7:0]  hi_byte;
    logic [7:0]  proto;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [31:0] src_sh;
    logic [31:0] dst_sh;

    logic        take;
    logic        in_hdr;
    logic        hdr_end;
    logic        hdr_ok;
    logic        pay_end;
    logic        ok_inc;
    logic        drop_inc;
    logic        seg_zero;
    logic [15:0] hdr_len;
    logic [15:0] seg_calc;
    logic [16:0] csum_sum;
    logic [15:0] csum_next;
    logic [31:0] dst_now;

    assign s_ready_o = !rst_i &&
                       ((state != PAYLOAD) || !m_valid_o || m_ready_i);
    assign take      = s_valid_i && s_ready_o;
    assign in_hdr    = (state == HDR) || (state == OPT);
    assign hdr_len   = {10'd0, ihl, 2'b00};
    assign seg_calc  = total_len - hdr_len;
    assign seg_zero  = (seg_calc == 16'd0);

    // End-around carry folded on every word keeps the sum in 16 bits.
    assign csum_sum  = {1'b0, csum} + {1'b0, hi_byte, s_data_i};
    assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};

    assign hdr_end = ((state == HDR) && (idx == 16'd19) && (ihl <= 4'd5)) ||
                     ((state == OPT) && (idx == hdr_len - 16'd1));

    assign hdr_ok = (version == 4'd4) &&
                    (ihl >= 4'd5) &&
                    (proto == 8'd6) &&
                    (csum_next == 16'hFFFF) &&
                    (total_len >= hdr_len);

    assign pay_end = (idx == total_len - 16'd1);

    // Without options the last destination byte is the final header byte.
    assign dst_now = (state == HDR) ? {dst_sh[23:0], s_data_i} : dst_sh;

    assign ok_inc = take && hdr_end && hdr_ok;

    assign drop_inc = take && (
        (in_hdr && s_last_i && !(hdr_end && hdr_ok && seg_zero)) ||
        (hdr_end && !hdr_ok) ||
        ((state == PAYLOAD) && s_last_i && !pay_end));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= HDR;
            idx         <= '0;
            csum        <= '0;
            total_len   <= '0;
            hi_byte     <= '0;
            proto       <= '0;
            version     <= '0;
            ihl         <= '0;
            src_sh      <= '0;
            dst_sh      <= '0;
            m_data_o    <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            src_ip_o    <= '0;
            dst_ip_o    <= '0;
            seg_len_o   <= '0;
            hdr_valid_o <= 1'b0;
            ok_cnt_o    <= '0;
            drop_cnt_o  <= '0;
        end else begin
            hdr_valid_o <= 1'b0;

            if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end

            if (ok_inc && (ok_cnt_o != '1))
                ok_cnt_o <= ok_cnt_o + 1'b1;
            if (drop_inc && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + 1'b1;

            if (take) begin
                unique case (state)
                    HDR, OPT: begin
                        idx <= idx + 16'd1;
                        if (!idx[0])
                            hi_byte <= s_data_i;
                        else
                            csum <= csum_next;

                        case (idx)
                            16'd0: {version, ihl} <= s_data_i;
                            16'd2: total_len[15:8] <= s_data_i;
                            16'd3: total_len[7:0]  <= s_data_i;
                            16'd9: proto <= s_data_i;
                            16'd12, 16'd13, 16'd14, 16'd15:
                                src_sh <= {src_sh[23:0], s_data_i};
                            16'd16, 16'd17, 16'd18, 16'd19:
                                dst_sh <= {dst_sh[23:0], s_data_i};
                            default: ;
                        endcase

                        if (hdr_end) begin
                            if (hdr_ok) begin
                                hdr_valid_o <= 1'b1;
                                src_ip_o    <= src_sh;
                                dst_ip_o    <= dst_now;
                                seg_len_o   <= seg_calc;
                            end
                            if (hdr_ok && !seg_zero && !s_last_i) begin
                                state <= PAYLOAD;
                            end else if (s_last_i) begin
                                state <= HDR;
                                idx   <= '0;
                                csum  <= '0;
                            end else begin
                                state <= DISCARD;
                            end
                        end else if (s_last_i) begin
                            state <= HDR;
                            idx   <= '0;
                            csum  <= '0;
                        end else if ((state == HDR) && (idx == 16'd19)) begin
                            state <= OPT;
                        end
                    end

                    PAYLOAD: begin
                        idx       <= idx + 16'd1;
                        m_data_o  <= s_data_i;
                        m_valid_o <= 1'b1;
                        m_last_o  <= pay_end || s_last_i;
                        if (s_last_i) begin
                            state <= HDR;
                            idx   <= '0;
                            csum  <= '0;
                        end else if (pay_end) begin
                            state <= DISCARD;
                        end
                    end

                    DISCARD: begin
                        if (s_last_i) begin
                            state <= HDR;
                            idx   <= '0;
                            csum  <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Scoreboard bench for ipv4_rx_parser: directed datagrams plus random
// traffic checked against a datagram-level reference model.
module tb_ipv4_rx_parser;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic [31:0] src_ip_o;
    logic [31:0] dst_ip_o;
    logic [15:0] seg_len_o;
    logic        hdr_valid_o;
    logic [15:0] ok_cnt_o;
    logic [15:0] drop_cnt_o;

    always #5 clk_i = ~clk_i;

    ipv4_rx_parser #(.CNT_W(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_last_i   (s_last_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_last_o   (m_last_o),
        .m_ready_i  (m_ready_i),
        .src_ip_o   (src_ip_o),
        .dst_ip_o   (dst_ip_o),
        .seg_len_o  (seg_len_o),
        .hdr_valid_o(hdr_valid_o),
        .ok_cnt_o   (ok_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pkt[$];
    logic [8:0]  exp_q[$];
    logic [79:0] hdr_q[$];
    int          exp_ok   = 0;
    int          exp_drop = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_span = 0;
    bit          in_pkt = 0;

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: always, alternating, or random.
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = !m_ready_i;
                default: m_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents output.
    initial begin
        logic [9:0] held;
        logic [8:0] e;
        logic [79:0] h;
        bit stalled;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                stalled = 0;
                in_pkt = 0;
                continue;
            end
            if (stalled)
                chk("stall_hold", {m_valid_o, m_last_o, m_data_o}, held);
            stalled = m_valid_o && !m_ready_i;
            held = {m_valid_o, m_last_o, m_data_o};
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("seg_byte", {m_last_o, m_data_o}, e);
                    if (!in_pkt) begin
                        first_cyc = cyc;
                        in_pkt = 1;
                    end
                    if (e[8]) begin
                        last_span = cyc - first_cyc + 1;
                        in_pkt = 0;
                    end
                end
            end
            if (hdr_valid_o) begin
                if (hdr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_hdr: got %0h expected none",
                             src_ip_o);
                end else begin
                    h = hdr_q.pop_front();
                    chk("hdr_fields", {src_ip_o, dst_ip_o, seg_len_o}, h);
                end
            end
        end
    end

    task automatic build(int ver, int ihl, int proto, int tl, bit bad,
                         int n, logic [31:0] src, logic [31:0] dst);
        int hend;
        logic [31:0] s;
        logic [15:0] cs;
        hend = (ihl > 5) ? ihl * 4 : 20;
        pkt.delete();
        for (int i = 0; i < hend; i++)
            pkt.push_back(8'($urandom));
        pkt[0]  = {4'(ver), 4'(ihl)};
        pkt[1]  = 8'h00;
        pkt[2]  = tl[15:8];
        pkt[3]  = tl[7:0];
        pkt[9]  = 8'(proto);
        pkt[10] = 8'h00;
        pkt[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            pkt[12 + i] = src[31 - 8 * i -: 8];
            pkt[16 + i] = dst[31 - 8 * i -: 8];
        end
        s = 0;
        for (int i = 0; i < hend; i += 2)
            s += {16'd0, pkt[i], pkt[i + 1]};
        while ((s >> 16) != 0)
            s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        pkt[10] = cs[15:8];
        pkt[11] = cs[7:0];
        if (bad)
            pkt[11] = pkt[11] ^ 8'h01;
        while (pkt.size() < n)
            pkt.push_back(8'($urandom));
        while (pkt.size() > n)
            void'(pkt.pop_back());
    endtask

    // Reference model: decides a datagram's fate from its bytes alone.
    task automatic predict();
        int n, ihl, hend, hl, tl, seg, nout;
        logic [31:0] s;
        bit ok;
        n = pkt.size();
        ihl = pkt[0][3:0];
        hend = (ihl > 5) ? ihl * 4 : 20;
        hl = ihl * 4;
        if (n < hend) begin
            exp_drop++;
            return;
        end
        tl = {pkt[2], pkt[3]};
        s = 0;
        for (int i = 0; i < hend; i += 2)
            s += {16'd0, pkt[i], pkt[i + 1]};
        while ((s >> 16) != 0)
            s = (s & 32'hFFFF) + (s >> 16);
        ok = (pkt[0][7:4] == 4'd4) && (ihl >= 5) && (pkt[9] == 8'd6) &&
             (s == 32'hFFFF) && (tl >= hl);
        if (!ok) begin
            exp_drop++;
            return;
        end
        exp_ok++;
        seg = tl - hl;
        hdr_q.push_back({pkt[12], pkt[13], pkt[14], pkt[15],
                         pkt[16], pkt[17], pkt[18], pkt[19], 16'(seg)});
        nout = (tl <= n) ? seg : n - hl;
        for (int i = 0; i < nout; i++)
            exp_q.push_back({i == nout - 1, pkt[hl + i]});
        if (n < tl)
            exp_drop++;
    endtask

    task automatic send(bit mark_last);
        int cnt;
        bit acc;
        for (int i = 0; i < pkt.size(); i++) begin
            s_valid_i = 1'b1;
            s_data_i  = pkt[i];
            s_last_i  = mark_last && (i == pkt.size() - 1);
            cnt = 0;
            do begin
                @(negedge clk_i);
                acc = s_ready_o;
                @(posedge clk_i);
                #1;
                cnt++;
            end while (!acc && cnt < 1000);
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_ready_timeout: got 0 expected 1");
                break;
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && cnt < 2000) begin
            @(negedge clk_i);
            cnt++;
        end
        chk("drain_pending", 80'(exp_q.size() + hdr_q.size()), 80'd0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic check_counts(string tag);
        chk({tag, "_ok_cnt"}, ok_cnt_o, 80'(exp_ok));
        chk({tag, "_drop_cnt"}, drop_cnt_o, 80'(exp_drop));
    endtask

    task automatic send_valid(int seg);
        build(4, 5, 6, 20 + seg, 0, 20 + seg, $urandom, $urandom);
        predict();
        send(1);
    endtask

    task automatic rand_pkt();
        int ver, ihl, proto, tl, n, hend, hl, seg, mode;
        bit bad;
        ver = ($urandom_range(0, 9) == 0) ? 6 : 4;
        case ($urandom_range(0, 9))
            0:       ihl = 4;
            1, 2:    ihl = 6;
            3:       ihl = 7;
            default: ihl = 5;
        endcase
        proto = ($urandom_range(0, 9) == 0) ? 17 : 6;
        bad = ($urandom_range(0, 9) == 0);
        hend = (ihl > 5) ? ihl * 4 : 20;
        hl = ihl * 4;
        seg = $urandom_range(0, 24);
        tl = hend + seg;
        if ($urandom_range(0, 14) == 0)
            tl = hl - 2;
        mode = $urandom_range(0, 9);
        if (mode < 6)
            n = tl;
        else if (mode < 8)
            n = tl + $urandom_range(1, 6);
        else if (mode == 8)
            n = $urandom_range(1, hend - 1);
        else
            n = (tl > hend) ? $urandom_range(hend, tl - 1) : hend;
        if (n < 1)
            n = 1;
        build(ver, ihl, proto, tl, bad, n, $urandom, $urandom);
        predict();
        send(1);
    endtask

    initial begin
        rst_i = 1'b1;
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
        s_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_m_last", m_last_o, 0);
        chk("rst_hdr_valid", hdr_valid_o, 0);
        chk("rst_ok_cnt", ok_cnt_o, 0);
        chk("rst_drop_cnt", drop_cnt_o, 0);
        chk("rst_ips", {src_ip_o, dst_ip_o, seg_len_o}, 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        rdy_mode = 0;
        build(4, 5, 6, 40, 0, 40, 32'h0A000001, 32'h0A000002);
        predict();
        send(1);
        drain();
        chk("basic_span", last_span, 20);
        chk("basic_seg_len", seg_len_o, 20);
        chk("basic_src", src_ip_o, 32'h0A000001);
        check_counts("basic");

        build(4, 5, 6, 40, 1, 40, 32'h0A000001, 32'h0A000002);
        predict();
        send(1);
        send_valid(20);
        drain();
        check_counts("bad_csum");

        build(4, 6, 6, 44, 0, 50, 32'hC0A80001, 32'hC0A80002);
        predict();
        send(1);
        drain();
        check_counts("options");

        build(4, 5, 17, 40, 0, 40, $urandom, $urandom);
        predict();
        send(1);
        build(4, 5, 6, 40, 0, 11, $urandom, $urandom);
        predict();
        send(1);
        send_valid(7);
        drain();
        check_counts("udp_trunc");

        rdy_mode = 1;
        send_valid(32);
        drain();
        rdy_mode = 0;
        check_counts("toggle");

        rdy_mode = 2;
        repeat (60) rand_pkt();
        drain();
        rdy_mode = 0;
        check_counts("random");

        build(4, 5, 6, 40, 0, 25, $urandom, $urandom);
        hdr_q.push_back({pkt[12], pkt[13], pkt[14], pkt[15],
                         pkt[16], pkt[17], pkt[18], pkt[19], 16'd20});
        for (int i = 0; i < 5; i++)
            exp_q.push_back({1'b0, pkt[20 + i]});
        send(0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        hdr_q.delete();
        chk("midrst_m_valid", m_valid_o, 0);
        chk("midrst_ok_cnt", ok_cnt_o, 0);
        chk("midrst_drop_cnt", drop_cnt_o, 0);
        rst_i = 1'b0;
        exp_ok = 0;
        exp_drop = 0;
        @(posedge clk_i);
        #1;
        send_valid(12);
        drain();
        check_counts("after_rst");

        chk("final_queues", 80'(exp_q.size() + hdr_q.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
